// File: rtl/serial_strobe_tx_if.sv
// serial_strobe_tx_if: load request, word and registered strobe/data outputs of the serial transmitter
interface serial_strobe_tx_if #(parameter int WIDTH = 8);
  logic             Load;
  logic [WIDTH-1:0] Data;
  logic             SClk;
  logic             SD;
  logic             Busy;
  logic             Done;
  modport master (output Load, Data, input SClk, SD, Busy, Done);
  modport slave  (input Load, Data, output SClk, SD, Busy, Done);
endinterface

// File: rtl/serial_strobe_tx.sv
// serial_strobe_tx: MSB-first parallel-to-serial transmitter with SD changing only while SClk is low
module serial_strobe_tx #(
  parameter int WIDTH       = 8,
  parameter int HALF_PERIOD = 4
) (
  input logic              Clk,
  input logic              Reset,
  serial_strobe_tx_if.slave bus
);
  localparam int PW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             sclk_q, sclk_d, sd_q, sd_d, busy_q, busy_d, done_q, done_d;
  logic             half_end;
  assign half_end = phase_q == PW'(HALF_PERIOD - 1);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    phase_d = half_end ? '0 : phase_q + 1'b1;
    sclk_d  = sclk_q;
    sd_d    = sd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.Load) begin
        state_d = LOW;
        sr_d    = bus.Data;
        bit_d   = '0;
        phase_d = '0;
        sclk_d  = 1'b0;
        sd_d    = bus.Data[WIDTH-1];
        busy_d  = 1'b1;
      end
      LOW: if (half_end) begin
        state_d = HIGH;
        sclk_d  = 1'b1;
      end
      HIGH: if (half_end) begin
        sclk_d = 1'b0;
        if (bit_q != BW'(WIDTH - 1)) begin
          // next bit lands on the same edge as the strobe fall
          state_d = LOW;
          sr_d    = sr_q << 1;
          bit_d   = bit_q + 1'b1;
          sd_d    = sr_d[WIDTH-1];
        end else begin
          state_d = IDLE;
          sd_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      sclk_q  <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.SClk = sclk_q;
  assign bus.SD   = sd_q;
  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
endmodule

// File: tb/tb_serial_strobe_tx.sv
// tb_serial_strobe_tx: directed checks of the serial transmitter at H=2 (dut a) and H=1 (dut b)
module tb_serial_strobe_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  serial_strobe_tx_if #(.WIDTH(8)) ia();
  serial_strobe_tx_if #(.WIDTH(8)) ib();
  serial_strobe_tx #(.WIDTH(8), .HALF_PERIOD(2)) ua (.Clk(clk), .Reset(rst), .bus(ia));
  serial_strobe_tx #(.WIDTH(8), .HALF_PERIOD(1)) ub (.Clk(clk), .Reset(rst), .bus(ib));
  typedef struct {
    int         n;
    logic       load;
    logic [7:0] data;
    logic       sclk, sd, busy, done;
  } vec_t;
  vec_t tbl[$];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  initial begin
    logic [7:0] rx;
    logic       prev_sclk, prev_sd;
    int         j, busy_n, done1, done2, gap;
    // n = edges since the accepting edge k; load/data are driven after the sample for the next edge
    tbl.push_back('{0,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{2,  1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{3,  1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{4,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{5,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{6,  1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{12, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{14, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{16, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{20, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{22, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{28, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{31, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{32, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{33, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0});
    ia.Load = 1'b1; ia.Data = 8'hFF;
    ib.Load = 1'b1; ib.Data = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("reset_a", {ia.SClk, ia.SD, ia.Busy, ia.Done}, 0);
      chk("reset_b", {ib.SClk, ib.SD, ib.Busy, ib.Done}, 0);
    end
    rst = 1'b0; ia.Load = 1'b0; ib.Load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_a", {ia.SClk, ia.SD, ia.Busy, ia.Done}, 0);
    end
    // A5 at H=2 with an ignored FF load mid-transfer
    ia.Load = 1'b1; ia.Data = 8'hA5;
    tick;
    rx = 0; prev_sclk = 1'b0; prev_sd = 1'b0; j = 0; busy_n = 0;
    for (int n = 0; n < 34; n++) begin
      if (ia.SClk && !prev_sclk) rx = {rx[6:0], ia.SD};
      if (ia.SClk) chk("sd_stable", ia.SD, prev_sd);
      prev_sclk = ia.SClk; prev_sd = ia.SD;
      busy_n += int'(ia.Busy);
      if (j < tbl.size() && tbl[j].n == n) begin
        chk($sformatf("vec_n%0d", n), {ia.SClk, ia.SD, ia.Busy, ia.Done},
            {tbl[j].sclk, tbl[j].sd, tbl[j].busy, tbl[j].done});
        ia.Load = tbl[j].load; ia.Data = tbl[j].data;
        j++;
      end else ia.Load = 1'b0;
      tick;
    end
    chk("rx_a5", rx, 8'hA5);
    chk("busy_len", busy_n, 32);
    // back-to-back at H=1: 81 then 7E loaded in the Done cycle
    ib.Load = 1'b1; ib.Data = 8'h81;
    tick;
    ib.Load = 1'b0;
    rx = 0; prev_sclk = 1'b0; done1 = -1; done2 = -1; gap = 0;
    for (int n = 0; n < 60 && done2 < 0; n++) begin
      if (ib.SClk && !prev_sclk) rx = {rx[6:0], ib.SD};
      prev_sclk = ib.SClk;
      if (n >= 1 && n <= 32 && !ib.Busy) gap++;
      if (ib.Done) begin
        if (done1 < 0) begin
          done1 = n;
          chk("rx_81", rx, 8'h81);
          rx = 0;
          ib.Load = 1'b1; ib.Data = 8'h7E;
        end else begin
          done2 = n;
          chk("rx_7e", rx, 8'h7E);
        end
      end else ib.Load = 1'b0;
      if (done2 < 0) tick;
    end
    chk("b2b_done1", done1, 16);
    chk("b2b_done2", done2, 33);
    chk("b2b_gap", gap, 1);
    // reset asserted so that edge k+9 sees it
    ia.Load = 1'b1; ia.Data = 8'hA5;
    tick;
    ia.Load = 1'b0;
    for (int n = 0; n < 8; n++) tick;
    chk("mid_busy", ia.Busy, 1'b1);
    rst = 1'b1;
    tick;
    chk("mid_reset", {ia.SClk, ia.SD, ia.Busy, ia.Done}, 0);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick;
      chk("no_done", {ia.Busy, ia.Done}, 0);
    end
    ia.Load = 1'b1; ia.Data = 8'h3C;
    tick;
    ia.Load = 1'b0;
    rx = 0; prev_sclk = 1'b0; done1 = -1;
    for (int n = 0; n < 40 && done1 < 0; n++) begin
      if (ia.SClk && !prev_sclk) rx = {rx[6:0], ia.SD};
      prev_sclk = ia.SClk;
      if (ia.Done) done1 = n;
      else tick;
    end
    chk("rx_3c", rx, 8'h3C);
    chk("done_3c", done1, 32);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
